// File: rtl/sum_display_pkg.sv
// Shared types and constants for the sum_display block: FSM states,
// active-low seven-segment patterns (gfedcba) and the conversion base.
package sum_display_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [4:0] BASE10  = 5'd10;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal inputs (10-15) light nothing.
module seg7_decode
    import sum_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/sum_display.sv
// Captures a 5-bit sum, converts it to two BCD digits by repeated
// subtraction of ten, and drives a two-digit multiplexed active-low display.
module sum_display
    import sum_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sum_in,
    input  logic       load,
    output logic       busy,
    output logic       valid,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t           state_r, state_s;
    logic [4:0]       rem_r, rem_s;
    logic [1:0]       tw_r, tw_s;
    logic             commit_s;
    logic [1:0]       tens_r;
    logic [3:0]       ones_r;
    logic             valid_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sel_r;
    logic [3:0]       digit_s;
    logic [6:0]       dec_s;
    logic [1:0]       an_s, an_r;
    logic [6:0]       seg_s, seg_r;

    // Conversion FSM next-state and working-register update
    always_comb begin
        state_s  = state_r;
        rem_s    = rem_r;
        tw_s     = tw_r;
        commit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (load) begin
                    rem_s   = sum_in;
                    tw_s    = 2'd0;
                    state_s = CONV;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                if (rem_r >= BASE10) begin
                    rem_s = rem_r - BASE10;
                    tw_s  = tw_r + 2'd1;
                end else begin
                    commit_s = 1'b1;
                    state_s  = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state, working registers and committed display value
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            rem_r   <= 5'd0;
            tw_r    <= 2'd0;
            tens_r  <= 2'd0;
            ones_r  <= 4'd0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
            tw_r    <= tw_s;
            if (commit_s) begin
                tens_r  <= tw_r;
                ones_r  <= rem_r[3:0];
                valid_r <= 1'b1;
            end
        end
    end

    // Free-running refresh counter and digit select
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            sel_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            sel_r <= ~sel_r;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign digit_s = sel_r ? {2'b00, tens_r} : ones_r;

    seg7_decode u_dec (
        .digit (digit_s),
        .seg   (dec_s)
    );

    // Digit enable and blanking selection, including leading-zero suppression
    always_comb begin
        an_s  = 2'b11;
        seg_s = SEG_OFF;
        if (!valid_r) begin
            an_s  = 2'b11;
            seg_s = SEG_OFF;
        end else if (!sel_r) begin
            an_s  = 2'b10;
            seg_s = dec_s;
        end else if (tens_r != 2'd0) begin
            an_s  = 2'b01;
            seg_s = dec_s;
        end else begin
            an_s  = 2'b11;
            seg_s = SEG_OFF;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= 2'b11;
            seg_r <= SEG_OFF;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
        end
    end

    assign busy  = (state_r == CONV);
    assign valid = valid_r;
    assign an    = an_r;
    assign seg   = seg_r;

endmodule

// File: tb/tb_sum_display.sv
// Scoreboard bench for sum_display: stimulus predicts commit edge and value,
// a negedge monitor checks busy, valid, commit timing and multiplexed digits.
module tb_sum_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [4:0] sum_in = 5'd0;
    logic       busy, valid;
    logic [1:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    sum_display #(.REFRESH_DIV(DIV), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .sum_in (sum_in),
        .load   (load),
        .busy   (busy),
        .valid  (valid),
        .an     (an),
        .seg    (seg)
    );

    typedef struct {
        int s;
        int c;
    } exp_t;

    exp_t sbq[$];
    exp_t ent;

    int j = -1;
    int total = 0, bad = 0;
    int cur_e = 0, cur_c = 0, busy_end = 0;
    int disp_valid = 0, disp_tens = 0, disp_ones = 0;
    int exp_an, exp_seg;
    bit prev_busy = 1'b0;
    int seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Edge index since the most recent reset edge
    always @(posedge clk) j <= rst ? 0 : j + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, j);
        end
    endtask

    // Monitor: compare DUT outputs against the model after every edge
    always @(negedge clk) begin
        if (j >= 0) begin
            if (j == 0) begin
                disp_valid = 0;
                exp_an = 3;
                exp_seg = 7'h7F;
            end else if (disp_valid == 0) begin
                exp_an = 3;
                exp_seg = 7'h7F;
            end else if (((j - 1) / DIV) % 2 == 0) begin
                exp_an = 2;
                exp_seg = seg_tab[disp_ones];
            end else if (disp_tens != 0) begin
                exp_an = 1;
                exp_seg = seg_tab[disp_tens];
            end else begin
                exp_an = 3;
                exp_seg = 7'h7F;
            end
            check("an", an, exp_an);
            check("seg", seg, exp_seg);
            check("busy", busy, (j >= cur_e && j < cur_c) ? 1 : 0);
            if (j != 0 && prev_busy && !busy) begin
                if (sbq.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    ent = sbq.pop_front();
                    check("commit_edge", j, ent.c);
                    disp_valid = 1;
                    disp_tens = ent.s / 10;
                    disp_ones = ent.s % 10;
                end
            end
            check("valid", valid, disp_valid);
            prev_busy = busy;
        end
    end

    // Drive one cycle of inputs and predict its effect
    task automatic cycle(input bit l, input int s, input bit r);
        @(negedge clk);
        #1;
        rst = r;
        load = l;
        sum_in = 5'(s);
        if (r) begin
            sbq.delete();
            cur_e = 0;
            cur_c = 0;
            busy_end = 0;
        end else if (l && (j + 1 > busy_end)) begin
            cur_e = j + 1;
            cur_c = cur_e + s / 10 + 1;
            busy_end = cur_c;
            sbq.push_back('{s, cur_c});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, int'($urandom_range(0, 31)), 1'b0);
    endtask

    initial begin
        repeat (3) cycle(1'b0, 0, 1'b1);
        idle(20);
        cycle(1'b1, 4, 1'b0);
        idle(12);
        cycle(1'b1, 19, 1'b0);
        idle(12);
        cycle(1'b1, 31, 1'b0);
        idle(1);
        cycle(1'b1, 5, 1'b0);
        idle(14);
        cycle(1'b1, 25, 1'b0);
        idle(1);
        cycle(1'b0, 0, 1'b1);
        idle(12);
        cycle(1'b1, 10, 1'b0);
        idle(2);
        cycle(1'b1, 0, 1'b0);
        idle(12);
        repeat (40) begin
            cycle(1'b1, int'($urandom_range(0, 31)), 1'b0);
            idle(int'($urandom_range(0, 12)));
        end
        idle(10);
        check("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
